// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one 6530 interval timer between NREQ requesters.
// Optional watchdog abort on a stuck timer: define TIMER_ARB_TIMEOUT_EN.
module timer_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*8-1:0] req_count_i,
  input  logic [NREQ*2-1:0] req_div_i,
  output logic [NREQ-1:0]   grant_o,
  output logic [NREQ-1:0]   done_o,
  output logic [NREQ-1:0]   err_o,
  output logic              busy_o,
  output logic [7:0]        remaining_o,
  output logic              t_enable_o,
  output logic              t_we_n_o,
  output logic [2:0]        t_a_o,
  output logic [7:0]        t_di_o,
  input  logic [7:0]        t_do_i,
  input  logic              t_irq_i
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StAck} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic              wait_first_q, wait_first_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [7:0]        remaining_q, remaining_d;
  logic              t_enable_q, t_enable_d;
  logic              t_we_n_q, t_we_n_d;
  logic [2:0]        t_a_q, t_a_d;
  logic [7:0]        t_di_q, t_di_d;

`ifdef TIMER_ARB_TIMEOUT_EN
  logic [19:0]       wd_q, wd_d;
`else
  logic [19:0]       unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  logic [7:0]        count_arr [NREQ];
  logic [1:0]        div_arr   [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign count_arr[g] = req_count_i[8*g +: 8];
    assign div_arr[g]   = req_div_i[2*g +: 2];
  end

  // First requesting index at or after rr_ptr, wrapping modulo NREQ.
  logic            any_req;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] win_next;

  always_comb begin : p_arb
    logic [IdxW-1:0] cand;
    any_req = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IdxW'((32'(rr_ptr_q) + i) % NREQ);
      if (!any_req && req_i[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
    win_next = IdxW'((32'(win_idx) + 32'd1) % NREQ);
  end

  always_comb begin : p_next
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    wait_first_d = 1'b0;
    grant_d      = grant_q;
    done_d       = '0;
    err_d        = '0;
    remaining_d  = remaining_q;
    t_enable_d   = 1'b0;
    t_we_n_d     = 1'b1;
    t_a_d        = 3'b000;
    t_di_d       = t_di_q;
`ifdef TIMER_ARB_TIMEOUT_EN
    wd_d         = wd_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d           = win_idx;
          rr_ptr_d          = win_next;
          grant_d           = '0;
          grant_d[win_idx]  = 1'b1;
          t_enable_d        = 1'b1;
          if (count_arr[win_idx] != 8'd0) begin
            state_d  = StLoad;
            t_we_n_d = 1'b0;
            t_a_d    = {1'b1, div_arr[win_idx]};
            t_di_d   = count_arr[win_idx];
          end else begin
            // Zero interval skips the timer entirely but still completes.
            state_d          = StAck;
            done_d           = '0;
            done_d[win_idx]  = 1'b1;
          end
        end
      end

      StLoad: begin
        state_d      = StWait;
        t_enable_d   = 1'b1;
        t_a_d        = 3'b100;
        wait_first_d = 1'b1;
`ifdef TIMER_ARB_TIMEOUT_EN
        wd_d         = '0;
`endif
      end

      StWait: begin
        t_enable_d = 1'b1;
        t_a_d      = 3'b100;
        // The first WAIT cycle only issues the read address; data is valid afterwards.
        if (!wait_first_q) begin
          remaining_d = t_do_i;
        end
`ifdef TIMER_ARB_TIMEOUT_EN
        wd_d = wd_q + 20'd1;
`endif
        if (!t_irq_i) begin
          state_d = StAck;
          t_a_d   = 3'b000;
          done_d  = grant_q;
        end else if (!req_i[owner_q]) begin
          state_d = StAck;
          t_a_d   = 3'b000;
        end
`ifdef TIMER_ARB_TIMEOUT_EN
        else if (wd_q == TIMEOUT) begin
          state_d = StAck;
          t_a_d   = 3'b000;
          err_d   = grant_q;
        end
`endif
      end

      StAck: begin
        state_d = StIdle;
        grant_d = '0;
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      wait_first_q <= 1'b0;
      grant_q      <= '0;
      done_q       <= '0;
      err_q        <= '0;
      remaining_q  <= '0;
      t_enable_q   <= 1'b0;
      t_we_n_q     <= 1'b1;
      t_a_q        <= 3'b000;
      t_di_q       <= '0;
`ifdef TIMER_ARB_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      wait_first_q <= wait_first_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      err_q        <= err_d;
      remaining_q  <= remaining_d;
      t_enable_q   <= t_enable_d;
      t_we_n_q     <= t_we_n_d;
      t_a_q        <= t_a_d;
      t_di_q       <= t_di_d;
`ifdef TIMER_ARB_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign grant_o     = grant_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != StIdle);
  assign remaining_o = remaining_q;
  assign t_enable_o  = t_enable_q;
  assign t_we_n_o    = t_we_n_q;
  assign t_a_o       = t_a_q;
  assign t_di_o      = t_di_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level model of arbitration and timer handshake.
module tb_timer_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*8-1:0] req_count;
  logic [N*2-1:0] req_div;
  logic [N-1:0]  grant, done, err;
  logic          busy;
  logic [7:0]    remaining;
  logic          t_enable, t_we_n;
  logic [2:0]    t_a;
  logic [7:0]    t_di;
  logic [7:0]    t_do;
  logic          t_irq;

  int checks = 0;
  int errors = 0;
  int m_rr   = 0;
  logic [7:0] exp_rem = 8'd0;

  timer_arbiter #(.NREQ(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .req_count_i (req_count),
    .req_div_i   (req_div),
    .grant_o     (grant),
    .done_o      (done),
    .err_o       (err),
    .busy_o      (busy),
    .remaining_o (remaining),
    .t_enable_o  (t_enable),
    .t_we_n_o    (t_we_n),
    .t_a_o       (t_a),
    .t_di_o      (t_di),
    .t_do_i      (t_do),
    .t_irq_i     (t_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spec rule: first set request at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rem"}, remaining, 0);
    chk({tag, "_en"}, t_enable, 0);
    chk({tag, "_we_n"}, t_we_n, 1);
    chk({tag, "_a"}, t_a, 0);
    chk({tag, "_di"}, t_di, 0);
  endtask

  task automatic chk_idle();
    chk("idle_grant", grant, 0);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_en", t_enable, 0);
    chk("idle_we_n", t_we_n, 1);
  endtask

  // mode: 0 = irq ends interval, 1 = owner cancels, 2 = irq and cancel together.
  task automatic do_txn(input int irq_delay, input int mode);
    int         w;
    logic [N-1:0] oh;
    logic [7:0] cnt;
    logic [1:0] dv;
    logic [7:0] dov;
    bit         last;
    w   = pick(req, m_rr);
    oh  = '0;
    oh[w] = 1'b1;
    cnt = req_count[8*w +: 8];
    dv  = req_div[2*w +: 2];
    t_irq = 1'($urandom_range(0, 1));
    step();
    m_rr = (w + 1) % N;
    chk("grant", grant, oh);
    chk("busy", busy, 1);
    req_count = $urandom;
    req_div   = 8'($urandom);
    if (cnt == 8'd0) begin
      chk("zc_en", t_enable, 1);
      chk("zc_we_n", t_we_n, 1);
      chk("zc_a", t_a, 0);
      chk("zc_done", done, oh);
      t_irq = 1'b1;
      step();
      chk_idle();
      return;
    end
    chk("load_en", t_enable, 1);
    chk("load_we_n", t_we_n, 0);
    chk("load_a", t_a, {1'b1, dv});
    chk("load_di", t_di, cnt);
    chk("load_done", done, 0);
    t_irq = 1'($urandom_range(0, 1));
    step();
    t_irq = 1'b1;
    for (int j = 1; ; j++) begin
      chk("wait_en", t_enable, 1);
      chk("wait_we_n", t_we_n, 1);
      chk("wait_a", t_a, 3'b100);
      chk("wait_grant", grant, oh);
      chk("wait_done", done, 0);
      chk("wait_rem", remaining, exp_rem);
      dov  = 8'($urandom);
      t_do = dov;
      last = (j == irq_delay + 1);
      if (last) begin
        if (mode != 0) req[w] = 1'b0;
        if (mode != 1) t_irq = 1'b0;
      end
      step();
      if (j >= 2) exp_rem = dov;
      if (last) break;
    end
    chk("ack_en", t_enable, 1);
    chk("ack_we_n", t_we_n, 1);
    chk("ack_a", t_a, 3'b000);
    chk("ack_done", done, (mode == 1) ? '0 : oh);
    chk("ack_err", err, 0);
    chk("ack_grant", grant, oh);
    chk("ack_rem", remaining, exp_rem);
    t_irq = 1'b1;
    step();
    chk_idle();
  endtask

  initial begin
    rst = 1'b1; req = '0; req_count = '0; req_div = '0; t_do = '0; t_irq = 1'b1;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();
    chk_idle();

    // Single requester, count 5, divide by 1.
    req = 4'b0001; req_count = 32'h0000_0005; req_div = '0;
    do_txn(6, 0);
    req = '0;

    // Two requesters alternate fairly: 1, 3, 1, 3.
    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      req_count = {8'd9, 8'd0, 8'd7, 8'd0};
      req_div   = 8'b10_00_01_00;
      do_txn(i + 1, 0);
    end
    req = '0;

    // Zero count completes without a write.
    req = 4'b0100; req_count = '0;
    do_txn(0, 0);
    req = '0;

    // Owner cancels mid-WAIT; next requester is then served.
    req = 4'b0011; req_count = {8'd0, 8'd0, 8'd3, 8'd4}; req_div = 8'b00_00_11_10;
    do_txn(3, 1);
    req_count = {8'd0, 8'd0, 8'd3, 8'd4};
    do_txn(2, 0);
    req = '0;

    // irq and cancel in the same cycle: irq wins.
    req = 4'b1000; req_count = {8'd20, 24'd0};
    do_txn(1, 2);
    req = '0;

    // Reset during WAIT abandons the owner silently.
    req = 4'b0001; req_count = 32'd8;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk_reset_vals("rst_wait");
    rst = 1'b0; req = '0; m_rr = 0; exp_rem = 8'd0;
    step();
    chk_idle();

    // Randomized transactions.
    for (int it = 0; it < 60; it++) begin
      req = 4'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) begin
        req_count[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      req_div = 8'($urandom);
      if (req == '0) begin
        t_irq = 1'($urandom_range(0, 1));
        step();
        chk_idle();
        t_irq = 1'b1;
      end else begin
        do_txn($urandom_range(0, 8),
               ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 5) == 0) ? 2 : 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
